// File: rtl/reg_cmd_pkg.sv
// Shared opcodes and FSM state encoding for the
// register command controller.
package reg_cmd_pkg;

  localparam logic [7:0] CMD_WR = 8'hAA;
  localparam logic [7:0] CMD_RD = 8'hBB;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    TX_HOLD
  } state_e;

  function automatic logic is_frame_st(state_e s);
    return (s == WR_ADDR) || (s == WR_DATA) || (s == RD_ADDR);
  endfunction

endpackage

// File: rtl/cmd_timeout_cnt.sv
// Idle-cycle counter for partial command frames;
// expired is high once the count reaches TIMEOUT-1.
module cmd_timeout_cnt #(
  parameter int TIMEOUT = 1024,
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CW-1:0] cnt_q;

  assign expired = (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && !expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/reg_cmd_ctrl.sv
// Byte-stream command decoder driving a register file:
// AA,addr,data writes; BB,addr reads and returns the byte.
module reg_cmd_ctrl
  import reg_cmd_pkg::*;
#(
  parameter int ADDR_WD = 3,
  parameter int DATA_WD = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [DATA_WD-1:0] RX_P_DATA,
  input  logic               RX_D_VLD,
  input  logic [DATA_WD-1:0] RF_RdData,
  output logic               RF_WrEn,
  output logic               RF_RdEn,
  output logic [ADDR_WD-1:0] RF_Address,
  output logic [DATA_WD-1:0] RF_WrData,
  output logic [DATA_WD-1:0] TX_P_DATA,
  output logic               TX_D_VLD,
  input  logic               TX_BUSY,
  output logic               CMD_ERR
);

  state_e             state_q;
  logic [ADDR_WD-1:0] addr_q;
  logic [ADDR_WD-1:0] rf_addr_q;
  logic [DATA_WD-1:0] wr_data_q;
  logic [DATA_WD-1:0] tx_data_q;
  logic               wr_en_q;
  logic               rd_en_q;
  logic               tx_vld_q;
  logic               err_q;

  logic expired;
  logic cnt_clr;
  logic cnt_en;
  logic addr_ok;
  logic is_wr;
  logic is_rd;

  assign is_wr   = (RX_P_DATA == DATA_WD'(CMD_WR));
  assign is_rd   = (RX_P_DATA == DATA_WD'(CMD_RD));
  assign addr_ok = ((RX_P_DATA >> ADDR_WD) == '0);
  assign cnt_clr = RX_D_VLD || (state_q == IDLE);
  assign cnt_en  = is_frame_st(state_q);

  cmd_timeout_cnt #(
    .TIMEOUT(TIMEOUT)
  ) u_tmo (
    .CLK    (CLK),
    .RST    (RST),
    .clear  (cnt_clr),
    .enable (cnt_en),
    .expired(expired)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      rf_addr_q <= '0;
      wr_data_q <= '0;
      tx_data_q <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      tx_vld_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (RX_D_VLD) begin
            unique case (1'b1)
              is_wr:   state_q <= WR_ADDR;
              is_rd:   state_q <= RD_ADDR;
              default: err_q   <= 1'b1;
            endcase
          end
        end
        WR_ADDR, RD_ADDR: begin
          if (RX_D_VLD) begin
            if (!addr_ok) begin
              err_q   <= 1'b1;
              state_q <= IDLE;
            end else begin
              addr_q <= RX_P_DATA[ADDR_WD-1:0];
              if (state_q == WR_ADDR) begin
                state_q <= WR_DATA;
              end else begin
                state_q   <= RD_WAIT;
                rd_en_q   <= 1'b1;
                rf_addr_q <= RX_P_DATA[ADDR_WD-1:0];
              end
            end
          end else if (expired) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        WR_DATA: begin
          if (RX_D_VLD) begin
            wr_en_q   <= 1'b1;
            rf_addr_q <= addr_q;
            wr_data_q <= RX_P_DATA;
            state_q   <= IDLE;
          end else if (expired) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        // read data lands one cycle after the strobe cycle
        RD_WAIT: begin
          err_q <= RX_D_VLD;
          if (!rd_en_q) begin
            tx_data_q <= RF_RdData;
            tx_vld_q  <= 1'b1;
            state_q   <= TX_HOLD;
          end
        end
        TX_HOLD: begin
          err_q <= RX_D_VLD;
          if (!TX_BUSY) begin
            tx_vld_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign RF_WrEn    = wr_en_q;
  assign RF_RdEn    = rd_en_q;
  assign RF_Address = rf_addr_q;
  assign RF_WrData  = wr_data_q;
  assign TX_P_DATA  = tx_data_q;
  assign TX_D_VLD   = tx_vld_q;
  assign CMD_ERR    = err_q;

endmodule

// File: tb/tb_reg_cmd_ctrl.sv
// Scoreboard bench for reg_cmd_ctrl: stimulus pushes
// expected events with cycle stamps, a monitor pops them.
module tb_reg_cmd_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] RX_P_DATA = '0;
  logic       RX_D_VLD = 1'b0;
  logic [7:0] RF_RdData = '0;
  logic       TX_BUSY = 1'b0;
  logic       RF_WrEn;
  logic       RF_RdEn;
  logic [2:0] RF_Address;
  logic [7:0] RF_WrData;
  logic [7:0] TX_P_DATA;
  logic       TX_D_VLD;
  logic       CMD_ERR;

  typedef enum int {EV_WR, EV_RD, EV_TX, EV_ERR, EV_TXEND} ev_e;
  typedef struct {
    ev_e        kind;
    int         cyc;
    logic [2:0] addr;
    logic [7:0] data;
  } ev_t;

  ev_t        q[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic       tx_prev = 1'b0;
  logic [7:0] tx_hold = '0;
  logic [7:0] mem [8];

  reg_cmd_ctrl #(
    .ADDR_WD(3),
    .DATA_WD(8),
    .TIMEOUT(16)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .RX_P_DATA (RX_P_DATA),
    .RX_D_VLD  (RX_D_VLD),
    .RF_RdData (RF_RdData),
    .RF_WrEn   (RF_WrEn),
    .RF_RdEn   (RF_RdEn),
    .RF_Address(RF_Address),
    .RF_WrData (RF_WrData),
    .TX_P_DATA (TX_P_DATA),
    .TX_D_VLD  (TX_D_VLD),
    .TX_BUSY   (TX_BUSY),
    .CMD_ERR   (CMD_ERR)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(posedge CLK)
    if (RF_RdEn) RF_RdData <= mem[RF_Address];

  task automatic expect_ev(input ev_e k, input int c,
                           input logic [2:0] a, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    e.addr = a;
    e.data = d;
    q.push_back(e);
  endtask

  task automatic chk_ev(input ev_e k, input logic [2:0] a,
                        input logic [7:0] d);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s: cyc=%0d addr=%0d data=%h, want none",
               k.name(), cyc, a, d);
    end else begin
      e = q.pop_front();
      if (e.kind == EV_TX) tx_hold = e.data;
      if (e.kind != k || e.cyc != cyc || e.addr !== a || e.data !== d) begin
        errors++;
        $display("FAIL event_%s: got %s cyc=%0d addr=%0d data=%h, want %s cyc=%0d addr=%0d data=%h",
                 e.kind.name(), k.name(), cyc, a, d,
                 e.kind.name(), e.cyc, e.addr, e.data);
      end
    end
  endtask

  always @(negedge CLK) begin
    if (!RST) begin
      tx_prev = 1'b0;
    end else begin
      checks++;
      if (RF_WrEn && RF_RdEn) begin
        errors++;
        $display("FAIL wr_rd_excl: both strobes high at cyc %0d", cyc);
      end
      if (RF_WrEn) chk_ev(EV_WR, RF_Address, RF_WrData);
      if (RF_RdEn) chk_ev(EV_RD, RF_Address, 8'h00);
      if (TX_D_VLD && !tx_prev) chk_ev(EV_TX, 3'd0, TX_P_DATA);
      if (TX_D_VLD && tx_prev) begin
        checks++;
        if (TX_P_DATA !== tx_hold) begin
          errors++;
          $display("FAIL tx_hold: got %h want %h at cyc %0d",
                   TX_P_DATA, tx_hold, cyc);
        end
      end
      if (CMD_ERR) chk_ev(EV_ERR, 3'd0, 8'h00);
      if (!TX_D_VLD && tx_prev) chk_ev(EV_TXEND, 3'd0, 8'h00);
      tx_prev = TX_D_VLD;
    end
  end

  task automatic check(input string n, input logic [7:0] act,
                       input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  task automatic chk_zero(input string n);
    check({n, "_wren"}, {7'd0, RF_WrEn}, 8'h00);
    check({n, "_rden"}, {7'd0, RF_RdEn}, 8'h00);
    check({n, "_addr"}, {5'd0, RF_Address}, 8'h00);
    check({n, "_wdata"}, RF_WrData, 8'h00);
    check({n, "_txdata"}, TX_P_DATA, 8'h00);
    check({n, "_txvld"}, {7'd0, TX_D_VLD}, 8'h00);
    check({n, "_err"}, {7'd0, CMD_ERR}, 8'h00);
  endtask

  task automatic send(input logic [7:0] b, output int e);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    @(posedge CLK);
    #1;
    RX_D_VLD  = 1'b0;
    e = cyc;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    repeat (3000) @(posedge CLK);
    $display("FAIL watchdog: cyc=%0d, want finish before 3000", cyc);
    $fatal(1);
  end

  initial begin
    int e;
    int e2;
    for (int i = 0; i < 8; i++) mem[i] = 8'(i * 16 + 1);
    mem[1] = 8'h5A;
    mem[2] = 8'h81;
    mem[6] = 8'hC3;

    repeat (2) @(posedge CLK);
    #1;
    chk_zero("rst");
    RST = 1'b1;
    @(posedge CLK);
    #1;

    // writes, second frame back-to-back with the first WrEn
    send(8'hAA, e); send(8'h05, e); send(8'h3C, e);
    expect_ev(EV_WR, e, 3'd5, 8'h3C);
    send(8'hAA, e); send(8'h03, e); send(8'h7E, e);
    expect_ev(EV_WR, e, 3'd3, 8'h7E);
    wait_cyc(e + 2);

    // read, transmitter free
    send(8'hBB, e); send(8'h02, e);
    expect_ev(EV_RD, e, 3'd2, 8'h00);
    expect_ev(EV_TX, e + 2, 3'd0, 8'h81);
    expect_ev(EV_TXEND, e + 3, 3'd0, 8'h00);
    wait_cyc(e + 5);

    // read, transmitter busy for 10 cycles, overrun byte mid-hold
    TX_BUSY = 1'b1;
    send(8'hBB, e); send(8'h06, e);
    expect_ev(EV_RD, e, 3'd6, 8'h00);
    expect_ev(EV_TX, e + 2, 3'd0, 8'hC3);
    wait_cyc(e + 5);
    send(8'h11, e2);
    expect_ev(EV_ERR, e2, 3'd0, 8'h00);
    wait_cyc(e + 12);
    TX_BUSY = 1'b0;
    expect_ev(EV_TXEND, e + 13, 3'd0, 8'h00);
    wait_cyc(e + 15);

    // bad opcode, out-of-range write and read addresses
    send(8'h55, e);
    expect_ev(EV_ERR, e, 3'd0, 8'h00);
    send(8'hAA, e); send(8'h09, e);
    expect_ev(EV_ERR, e, 3'd0, 8'h00);
    send(8'hBB, e); send(8'hF2, e);
    expect_ev(EV_ERR, e, 3'd0, 8'h00);
    wait_cyc(e + 2);

    // timeouts in WR_DATA and WR_ADDR, then a normal read
    send(8'hAA, e); send(8'h01, e);
    expect_ev(EV_ERR, e + 16, 3'd0, 8'h00);
    wait_cyc(e + 18);
    send(8'hAA, e);
    expect_ev(EV_ERR, e + 16, 3'd0, 8'h00);
    wait_cyc(e + 18);
    send(8'hBB, e); send(8'h01, e);
    expect_ev(EV_RD, e, 3'd1, 8'h00);
    expect_ev(EV_TX, e + 2, 3'd0, 8'h5A);
    expect_ev(EV_TXEND, e + 3, 3'd0, 8'h00);
    wait_cyc(e + 5);

    // reset between address and data of a write
    send(8'hAA, e); send(8'h05, e);
    #2;
    RST = 1'b0;
    #1;
    chk_zero("mid_rst");
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    chk_zero("post_rst");
    send(8'h3C, e);
    expect_ev(EV_ERR, e, 3'd0, 8'h00);
    wait_cyc(e + 3);

    send(8'hAA, e); send(8'h07, e); send(8'hA5, e);
    expect_ev(EV_WR, e, 3'd7, 8'hA5);
    wait_cyc(e + 5);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_empty: %0d pending, want 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_cmd_ctrl.md
REG_CMD_CTRL -- requirements
Module: reg_cmd_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WD, default 3, register-file address width.
REQ-002 SHALL have parameter DATA_WD, default 8, register data width and command byte width.
REQ-003 SHALL have parameter TIMEOUT, default 1024, the idle-cycle limit inside a partial command frame.
REQ-004 SHALL have port CLK, input, 1, system clock.
REQ-005 SHALL have port RST, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port RX_P_DATA, input, DATA_WD, the received byte.
REQ-007 SHALL have port RX_D_VLD, input, 1, a one-cycle strobe marking RX_P_DATA valid.
REQ-008 SHALL have port RF_RdData, input, DATA_WD, register-file read data, valid exactly 1 cycle after the RF_RdEn cycle.
REQ-009 SHALL have port RF_WrEn, output, 1, register-file write strobe.
REQ-010 SHALL have port RF_RdEn, output, 1, register-file read strobe.
REQ-011 SHALL have port RF_Address, output, ADDR_WD, register-file address.
REQ-012 SHALL have port RF_WrData, output, DATA_WD, register-file write data.
REQ-013 SHALL have port TX_P_DATA, output, DATA_WD, the byte to transmit.
REQ-014 SHALL have port TX_D_VLD, output, 1, transmit request.
REQ-015 SHALL have port TX_BUSY, input, 1, transmitter busy.
REQ-016 SHALL have port CMD_ERR, output, 1, a one-cycle error pulse.

Function
REQ-017 SHALL decode two opcodes: CMD_WR = 8'hAA (frame: opcode, addr, data) and CMD_RD = 8'hBB (frame: opcode, addr).
REQ-018 SHALL implement FSM states IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_HOLD, with all outputs registered.
REQ-019 IDLE transitions on RX_D_VLD:
- 8'hAA -> WR_ADDR.
- 8'hBB -> RD_ADDR.
- Any other byte -> CMD_ERR pulse, remain in IDLE.
REQ-020 In WR_ADDR/RD_ADDR, an addr byte with any bit above ADDR_WD-1 set SHALL pulse CMD_ERR and return to IDLE, with no register-file access.
REQ-021 A valid addr byte SHALL be latched, then advance: WR_ADDR -> WR_DATA, RD_ADDR -> RD_WAIT.
REQ-022 In WR_DATA, on RX_D_VLD the next cycle SHALL drive RF_WrEn=1 for exactly one cycle, with RF_Address=latched addr and RF_WrData=byte; the FSM then returns to IDLE.
REQ-023 Entering RD_WAIT SHALL drive RF_RdEn=1 for exactly one cycle with RF_Address=latched addr.
REQ-024 The cycle after the RF_RdEn cycle SHALL capture RF_RdData into TX_P_DATA and enter TX_HOLD.
REQ-025 TX_HOLD SHALL handshake with the transmitter as follows:
- Hold TX_D_VLD=1 and TX_P_DATA stable until a cycle in which TX_D_VLD=1 and TX_BUSY=0.
- Deassert TX_D_VLD the next cycle and return to IDLE.
- Read latency from the addr-byte strobe to TX_D_VLD rising SHALL be 3 cycles when TX_BUSY=0.
REQ-026 RF_WrEn and RF_RdEn SHALL never be asserted in the same cycle.
REQ-027 RX_D_VLD arriving in RD_WAIT or TX_HOLD SHALL discard the byte and pulse CMD_ERR (overrun); the read in progress continues unaffected.
REQ-028 The timeout counter SHALL behave as follows:
- Clear on every RX_D_VLD and on every entry into IDLE.
- Count in WR_ADDR, WR_DATA and RD_ADDR.
- On reaching TIMEOUT-1: pulse CMD_ERR, return to IDLE, no access.
- Counter width SHALL be clog2(TIMEOUT).
REQ-029 In IDLE, a byte arriving in the same cycle as the preceding RF_WrEn pulse SHALL be decoded normally; back-to-back frames SHALL require no gap.

Reset
REQ-030 RST low SHALL asynchronously force:
- State IDLE.
- RF_WrEn, RF_RdEn, TX_D_VLD and CMD_ERR = 0.
- RF_Address, RF_WrData and TX_P_DATA = 0.
- Latched addr and timeout counter = 0.
REQ-031 Reset asserted mid-frame SHALL abandon the frame, with no RF_WrEn, RF_RdEn or TX_D_VLD after RST release until a new complete frame arrives.

Structure
REQ-032 Package reg_cmd_pkg SHALL hold the CMD_WR/CMD_RD opcode constants and the FSM state encoding.
REQ-033 The timeout counter SHALL be a separate sub-module, cmd_timeout_cnt: inputs clear and enable, output expired.

Verification
REQ-034 Write frame AA,05,3C -> exactly one RF_WrEn cycle with RF_Address=5 and RF_WrData=8'h3C, CMD_ERR stays 0.
REQ-035 Read frame BB,02 with RF_RdData=8'h81 and TX_BUSY=0 -> one RF_RdEn cycle at address 2, TX_D_VLD rises 3 cycles after the addr strobe with TX_P_DATA=8'h81.
REQ-036 Read with TX_BUSY=1 for 10 cycles -> TX_D_VLD and TX_P_DATA held for all 10 cycles, drop 1 cycle after TX_BUSY=0; an RX byte injected during the hold -> CMD_ERR pulse, read completes.
REQ-037 Bytes 55 then AA,09 -> CMD_ERR pulse for 55; CMD_ERR pulse for addr 9 (out of range at ADDR_WD=3); no register-file strobe.
REQ-038 With TIMEOUT=16, AA,01 followed by silence -> CMD_ERR at the 16th idle cycle, then BB,01 completes normally.
REQ-039 RST pulsed low between addr and data of a write -> no RF_WrEn; all outputs 0 during reset and after release.
